// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin arbiter in front of a 16-bit asynchronous SRAM.
// Each 32-bit word access becomes two halfword SRAM cycles (low, then high),
// each one setup cycle followed by WAIT_CYC+1 strobe cycles. All SRAM pins
// come straight from registers so the board sees clean, glitch-free strobes.
module sram_arb_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_vld,
    output logic              o_req0_rdy,
    input  logic [ADDR_W-2:0] i_req0_addr,
    input  logic              i_req0_we,
    input  logic [31:0]       i_req0_wdata,
    input  logic [3:0]        i_req0_bmask,
    input  logic              i_req1_vld,
    output logic              o_req1_rdy,
    input  logic [ADDR_W-2:0] i_req1_addr,
    input  logic              i_req1_we,
    input  logic [31:0]       i_req1_wdata,
    input  logic [3:0]        i_req1_bmask,
    output logic              o_rsp0_vld,
    output logic [31:0]       o_rsp0_rdata,
    output logic              o_rsp1_vld,
    output logic [31:0]       o_rsp1_rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);
    // Cycles per halfword: one setup plus WAIT_CYC+1 strobe cycles.
    localparam int N  = WAIT_CYC + 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [ADDR_W-2:0] addr_reg, addr_next;
    logic              we_reg, we_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        bmask_reg, bmask_next;
    logic              port_reg, port_next;
    logic              last_grant_reg, last_grant_next;

    logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
    logic              ce_n_reg, ce_n_next;
    logic              we_n_reg, we_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              lb_n_reg, lb_n_next;
    logic              ub_n_reg, ub_n_next;
    logic              dq_oe_reg, dq_oe_next;
    logic [15:0]       dq_out_reg, dq_out_next;

    logic [1:0]        vld, gnt, rdy;
    logic              half_end, capture, rsp_fire;
    logic              in_half, is_hi, strobe;
    logic [1:0]        half_mask;
    logic [1:0]        rsp_vld_reg;
    logic [31:0]       rdata_reg [2];

    // Round robin: a lone requester wins; on a tie the port not served last wins.
    assign vld        = {i_req1_vld, i_req0_vld};
    assign gnt[0]     = vld[0] & (~vld[1] | last_grant_reg);
    assign gnt[1]     = vld[1] & (~vld[0] | ~last_grant_reg);
    assign rdy        = (state_reg == IDLE && i_rst_n) ? gnt : 2'b00;
    assign o_req0_rdy = rdy[0];
    assign o_req1_rdy = rdy[1];

    assign half_end = (cnt_reg == LAST);
    assign capture  = (state_reg == LO || state_reg == HI) && half_end && !we_reg;
    assign rsp_fire = (state_reg == HI) && half_end;

    // Next state, half-cycle counter and request latch.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        we_next         = we_reg;
        wdata_next      = wdata_reg;
        bmask_next      = bmask_reg;
        port_next       = port_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (|rdy) begin
                    state_next      = LO;
                    cnt_next        = '0;
                    port_next       = rdy[1];
                    last_grant_next = rdy[1];
                    addr_next       = rdy[1] ? i_req1_addr  : i_req0_addr;
                    we_next         = rdy[1] ? i_req1_we    : i_req0_we;
                    wdata_next      = rdy[1] ? i_req1_wdata : i_req0_wdata;
                    bmask_next      = rdy[1] ? i_req1_bmask : i_req0_bmask;
                end
            end
            LO: begin
                cnt_next = half_end ? '0 : cnt_reg + CW'(1);
                if (half_end) state_next = HI;
            end
            HI: begin
                cnt_next = half_end ? '0 : cnt_reg + CW'(1);
                if (half_end) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pin values for the coming cycle, derived from where the FSM is heading.
    always_comb begin
        in_half        = (state_next == LO) || (state_next == HI);
        is_hi          = (state_next == HI);
        strobe         = in_half && (cnt_next != '0);
        half_mask      = is_hi ? bmask_next[3:2] : bmask_next[1:0];
        sram_addr_next = in_half ? {addr_next, is_hi} : sram_addr_reg;
        ce_n_next      = !in_half;
        oe_n_next      = !(strobe && !we_next);
        // A half whose two lane enables are both off keeps WE_N high.
        we_n_next      = !(strobe && we_next && (|half_mask));
        lb_n_next      = in_half ? (we_next & ~half_mask[0]) : 1'b1;
        ub_n_next      = in_half ? (we_next & ~half_mask[1]) : 1'b1;
        dq_oe_next     = in_half && we_next;
        dq_out_next    = is_hi ? wdata_next[31:16] : wdata_next[15:0];
    end

    // Control and pin registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            bmask_reg      <= '0;
            port_reg       <= 1'b0;
            last_grant_reg <= 1'b1;
            sram_addr_reg  <= '0;
            ce_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            lb_n_reg       <= 1'b1;
            ub_n_reg       <= 1'b1;
            dq_oe_reg      <= 1'b0;
            dq_out_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            wdata_reg      <= wdata_next;
            bmask_reg      <= bmask_next;
            port_reg       <= port_next;
            last_grant_reg <= last_grant_next;
            sram_addr_reg  <= sram_addr_next;
            ce_n_reg       <= ce_n_next;
            we_n_reg       <= we_n_next;
            oe_n_reg       <= oe_n_next;
            lb_n_reg       <= lb_n_next;
            ub_n_reg       <= ub_n_next;
            dq_oe_reg      <= dq_oe_next;
            dq_out_reg     <= dq_out_next;
        end
    end

    // Per-port response pulse and read-data capture on the last strobe of each half.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    rsp_vld_reg[gi] <= 1'b0;
                    rdata_reg[gi]   <= '0;
                end else begin
                    rsp_vld_reg[gi] <= rsp_fire && (port_reg == 1'(gi));
                    if (capture && (port_reg == 1'(gi))) begin
                        if (state_reg == HI) rdata_reg[gi][31:16] <= SRAM_DQ;
                        else                 rdata_reg[gi][15:0]  <= SRAM_DQ;
                    end
                end
            end
        end
    endgenerate

    assign o_rsp0_vld   = rsp_vld_reg[0];
    assign o_rsp1_vld   = rsp_vld_reg[1];
    assign o_rsp0_rdata = rdata_reg[0];
    assign o_rsp1_rdata = rdata_reg[1];

    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_CE_N = ce_n_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_LB_N = lb_n_reg;
    assign SRAM_UB_N = ub_n_reg;
    assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'hzzzz;
endmodule
